// File: rtl/axi_tap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_tap_pkg
//  Description : Shared types and constants for the AXI W-channel stream tap.
//                Holds the capture FSM state encoding, the drop counter width
//                and helpers that describe the {last, data} entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_tap_pkg;

   // Capture FSM states. IDLE is always a burst boundary.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DISCARD = 2'd2
   } cap_state_t;

   localparam int DROP_CNT_W = 16;

   // Capture entry layout: {last, data}, with last in the MSB.
   function automatic int entry_width(input int data_width);
      return data_width + 1;
   endfunction

   function automatic int entry_last_bit(input int data_width);
      return data_width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_fwft
//  Description : Single-clock first-word fall-through FIFO. The head entry is
//                visible on rdata_o whenever the FIFO is not empty.
//  Ports       : clk, resetn (sync, active low)
//                push_i/wdata_i  - write side (ignored when full)
//                pop_i           - remove the head (ignored when empty)
//                rdata_o         - head entry
//                count_o         - registered occupancy
//                empty_o         - occupancy is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
   assign pop_ok  = pop_i  && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the consumer masks the head while empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/axi_w_stream_tap.sv
`default_nettype none
// ============================================================================
//  Module      : axi_w_stream_tap
//  Description : AXI W-channel passthrough that also captures every forwarded
//                beat into a burst-aware FIFO and presents complete bursts on
//                a side stream. STALL_ON_FULL selects back-pressure (1) or
//                whole-burst capture dropping (0) when capture space is short.
//  Ports       : clk, resetn (sync, active low)
//                AXIS_w*       - upstream W channel (wready is an output)
//                AXIM_w*       - downstream W channel (wready is an input)
//                ready         - stream grant; a beat pops on ready & valid
//                valid         - at least one complete burst is captured
//                in_progress   - a captured burst is being streamed
//                data / last   - FIFO head (zero when empty)
//                drop_count    - saturating count of beats not captured
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_w_stream_tap
   import axi_tap_pkg::*;
#(
   parameter int DATA_WIDTH    = 128,
   parameter int ID_WIDTH      = 32,
   parameter int USER_WIDTH    = 64,
   parameter int BURST_LEN     = 8,
   parameter int FIFO_DEPTH    = 16,
   parameter int STALL_ON_FULL = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   // side stream
   input  logic                    ready,
   output logic                    valid,
   output logic                    in_progress,
   output logic [DATA_WIDTH-1:0]   data,
   output logic                    last,
   output logic [DROP_CNT_W-1:0]   drop_count,
   // upstream W channel
   input  logic [ID_WIDTH-1:0]     AXIS_wid,
   input  logic [DATA_WIDTH-1:0]   AXIS_wdata,
   input  logic [DATA_WIDTH/8-1:0] AXIS_wstrb,
   input  logic                    AXIS_wlast,
   input  logic [USER_WIDTH-1:0]   AXIS_wuser,
   input  logic                    AXIS_wvalid,
   output logic                    AXIS_wready,
   // downstream W channel
   output logic [ID_WIDTH-1:0]     AXIM_wid,
   output logic [DATA_WIDTH-1:0]   AXIM_wdata,
   output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
   output logic                    AXIM_wlast,
   output logic [USER_WIDTH-1:0]   AXIM_wuser,
   output logic                    AXIM_wvalid,
   input  logic                    AXIM_wready
);

   localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int BEAT_W   = $clog2(BURST_LEN + 1);
   localparam int ENTRY_W  = entry_width(DATA_WIDTH);
   localparam int LAST_BIT = entry_last_bit(DATA_WIDTH);

   cap_state_t             state_q, state_d;
   logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]       complete_q;
   logic                   mid_burst_q;
   logic [DROP_CNT_W-1:0]  drop_q;

   logic [CNT_W-1:0]       fifo_count;
   logic [CNT_W-1:0]       free_entries;
   logic                   fifo_empty;
   logic [ENTRY_W-1:0]     head;
   logic                   head_last;
   logic                   room;
   logic                   gate;
   logic                   accept;
   logic                   trunc;
   logic                   push;
   logic                   push_last;
   logic                   drop;
   logic                   pop;

   // ---------------------------------------------------------------------
   // Passthrough. Free space comes from the registered count only, so a
   // same-cycle pop never helps admit a new burst.
   // ---------------------------------------------------------------------
   assign free_entries = CNT_W'(FIFO_DEPTH) - fifo_count;
   assign room         = (free_entries >= CNT_W'(BURST_LEN));

   assign gate = !resetn ||
                 ((STALL_ON_FULL != 0) && (state_q == IDLE) && AXIS_wvalid && !room);

   assign AXIM_wid    = AXIS_wid;
   assign AXIM_wdata  = AXIS_wdata;
   assign AXIM_wstrb  = AXIS_wstrb;
   assign AXIM_wlast  = AXIS_wlast;
   assign AXIM_wuser  = AXIS_wuser;
   assign AXIM_wvalid = gate ? 1'b0 : AXIS_wvalid;
   assign AXIS_wready = gate ? 1'b0 : AXIM_wready;

   assign accept = AXIS_wvalid && AXIS_wready;

   // ---------------------------------------------------------------------
   // Capture FSM. beat_cnt_q is zero in IDLE, so the truncation test also
   // covers the first beat when BURST_LEN is 1.
   // ---------------------------------------------------------------------
   assign trunc = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      push       = 1'b0;
      push_last  = 1'b0;
      drop       = 1'b0;
      if (accept) begin
         unique case (state_q)
            IDLE, CAPTURE: begin
               // A burst is admitted at IDLE only with a full burst of room,
               // so CAPTURE never finds the FIFO full.
               if ((state_q == CAPTURE) || room) begin
                  push      = 1'b1;
                  push_last = AXIS_wlast || trunc;
                  if (AXIS_wlast) begin
                     state_d    = IDLE;
                     beat_cnt_d = '0;
                  end else if (trunc) begin
                     state_d    = DISCARD;
                     beat_cnt_d = '0;
                  end else begin
                     state_d    = CAPTURE;
                     beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                  end
               end else begin
                  drop = 1'b1;
                  if (!AXIS_wlast) begin
                     state_d = DISCARD;
                  end
               end
            end
            DISCARD: begin
               drop = 1'b1;
               if (AXIS_wlast) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d    = IDLE;
               beat_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Capture FIFO
   // ---------------------------------------------------------------------
   sync_fifo_fwft #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (push),
      .wdata_i ({push_last, AXIS_wdata}),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign head_last = head[LAST_BIT];

   // ---------------------------------------------------------------------
   // Stream side
   // ---------------------------------------------------------------------
   assign valid       = (complete_q != '0);
   assign pop         = ready && valid;
   assign in_progress = mid_burst_q || (valid && ready);
   assign data        = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
   assign last        = !fifo_empty && head_last;
   assign drop_count  = drop_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         complete_q  <= '0;
         mid_burst_q <= 1'b0;
         drop_q      <= '0;
      end else begin
         case ({push && push_last, pop && head_last})
            2'b10:   complete_q <= complete_q + CNT_W'(1);
            2'b01:   complete_q <= complete_q - CNT_W'(1);
            default: complete_q <= complete_q;
         endcase
         if (pop) begin
            mid_burst_q <= !head_last;
         end
         if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire
